usb_utmi_link_ctrl: RTL and testbench
=====================================

// Module: usb_utmi_link_ctrl
// PURPOSE
//  Full-speed UTMI link/bus-state controller for the device core. Sits between
//  the UTMI PHY line interface and the protocol engine: drives op_mode/term_select,
//  times line_state to detect bus reset, suspend and resume, and reports the
//  device bus state to the protocol/register layers.
// PARAMETERS
//  RESET_CYCLES    150     consecutive SE0 cycles => bus reset (2.5 us @ 60 MHz)
//  SUSPEND_CYCLES  180000  consecutive idle-J cycles => suspend (3 ms @ 60 MHz)
//  CNT_W           $clog2(SUSPEND_CYCLES+1)  shared timer width (derived)
// PORTS
//  clk          in   1  UTMI clock; all logic on rising edge
//  rst          in   1  synchronous reset, active-high
//  enable       in   1  software connect; 1 = pull-up on, link active
//  line_state   in   2  utmi_line_state_t from PHY, synchronous to clk
//  rx_active    in   1  PHY RxActive
//  tx_valid     in   1  TX path TxValid (bus activity from device)
//  op_mode      out  2  utmi_op_mode_t to PHY
//  term_select  out  1  1 = FS termination/pull-up enabled
//  bus_reset    out  1  1-cycle pulse on entry to RESET
//  in_reset     out  1  level, high while in RESET
//  suspend      out  1  level, high while in SUSPEND
//  resume       out  1  1-cycle pulse on SUSPEND->ACTIVE via K
//  link_state   out  2  00 DISABLED, 01 ACTIVE, 10 RESET, 11 SUSPEND
// BEHAVIOUR
//  Reset: state DISABLED, op_mode=UTMI_OM_NONDRIVE, term_select=0, bus_reset=0,
//   in_reset=0, suspend=0, resume=0, se0_cnt=0, idle_cnt=0. All outputs registered.
//  Qualifiers (per cycle): busy = rx_active|tx_valid; se0 = line_state==SE0 & !busy;
//   idle = line_state==DJ & !busy. SE1 or DK or busy clears both counters.
//  Counters: se0_cnt +1 while se0, else 0; idle_cnt +1 while idle, else 0;
//   both saturate at their threshold, both cleared on every state change.
//  "held N" = counter==N-1 and qualifier true this cycle -> transition on that edge.
//  FSM (enable==0 overrides all: next state DISABLED, counters cleared):
//   DISABLED: op_mode NONDRIVE, term_select 0. enable==1 -> ACTIVE next edge.
//   ACTIVE:   op_mode NORMAL, term_select 1. se0 held RESET_CYCLES -> RESET;
//             idle held SUSPEND_CYCLES -> SUSPEND. Both cannot coincide.
//   RESET:    in_reset=1; bus_reset=1 only first cycle in RESET. Stays while
//             line_state==SE0 (busy ignored); any other line_state -> ACTIVE.
//   SUSPEND:  suspend=1, op_mode NORMAL, term_select 1. line_state==DK -> ACTIVE
//             with resume=1 for the first ACTIVE cycle; se0 held RESET_CYCLES ->
//             RESET (reset from suspend, no resume pulse). DJ/SE1: stay.
//  Latency: op_mode/term_select change on the same edge as the state register.
//  enable deasserted mid-RESET/SUSPEND: next cycle DISABLED, in_reset/suspend=0,
//   no pulses. enable reasserted: ACTIVE with counters at 0.
//  link_state mirrors the FSM register; no other outputs depend on the inputs
//   combinationally.
// TESTING (RESET_CYCLES=8, SUSPEND_CYCLES=32)
//  rst 2 cycles, enable=0 -> op_mode=01, term_select=0, link_state=00, pulses 0.
//  enable=1, SE0 for 8 cycles -> link_state=10 on 8th edge, bus_reset 1 cycle,
//   in_reset high; line_state=DJ -> link_state=01 next edge, in_reset=0.
//  SE0 for 7 cycles then DJ, repeat -> never RESET; SE0 8 cycles with rx_active=1
//   on cycle 4 -> no RESET until 8 fresh qualifying cycles.
//  DJ idle 32 cycles -> suspend=1, link_state=11; DK 1 cycle -> link_state=01,
//   resume=1 exactly one cycle, suspend=0.
//  In SUSPEND, SE0 8 cycles -> link_state=10, bus_reset pulse, resume stays 0.
//  In RESET, drop enable -> link_state=00, op_mode=01, term_select=0, in_reset=0
//   next edge; re-enable -> 01 with idle count restarting from 0.

Source files
------------

// File: rtl/usb_utmi_link_ctrl.sv
// usb_utmi_link_ctrl
//   Full-speed UTMI link/bus-state controller. Drives op_mode/term_select to the
//   PHY, times line_state to detect bus reset, suspend and resume, and reports the
//   device bus state to the protocol and register layers.
// Ports
//   clk          UTMI clock, rising edge
//   rst          synchronous reset, active-high
//   enable       software connect (1 = pull-up on, link active)
//   line_state   PHY line state: 00 SE0, 01 J, 10 K, 11 SE1
//   rx_active    PHY RxActive
//   tx_valid     TX path TxValid
//   op_mode      PHY operating mode: 00 normal, 01 non-driving
//   term_select  1 = FS termination/pull-up enabled
//   bus_reset    1-cycle pulse on entry to RESET
//   in_reset     high while in RESET
//   suspend      high while in SUSPEND
//   resume       1-cycle pulse on SUSPEND->ACTIVE via K
//   link_state   00 DISABLED, 01 ACTIVE, 10 RESET, 11 SUSPEND
module usb_utmi_link_ctrl #(
  parameter int unsigned RESET_CYCLES   = 150,
  parameter int unsigned SUSPEND_CYCLES = 180000,
  localparam int unsigned CNT_W         = $clog2(SUSPEND_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] line_state,
  input  logic       rx_active,
  input  logic       tx_valid,
  output logic [1:0] op_mode,
  output logic       term_select,
  output logic       bus_reset,
  output logic       in_reset,
  output logic       suspend,
  output logic       resume,
  output logic [1:0] link_state
);

  localparam logic [1:0] LsSe0      = 2'b00;
  localparam logic [1:0] LsDj       = 2'b01;
  localparam logic [1:0] LsDk       = 2'b10;
  localparam logic [1:0] OmNormal   = 2'b00;
  localparam logic [1:0] OmNonDrive = 2'b01;

  // Encoding doubles as the link_state output code.
  typedef enum logic [1:0] {
    StDisabled = 2'b00,
    StActive   = 2'b01,
    StReset    = 2'b10,
    StSuspend  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             bus_reset_d, resume_d;
  logic             busy, se0, idle, se0_held, idle_held;

  // Any device or host traffic disqualifies the line from being timed.
  assign busy      = rx_active | tx_valid;
  assign se0       = (line_state == LsSe0) & ~busy;
  assign idle      = (line_state == LsDj) & ~busy;
  // Counter already at N-1 plus a qualifying cycle now means held for N cycles.
  assign se0_held  = se0 & (se0_cnt_q == CNT_W'(RESET_CYCLES - 1));
  assign idle_held = idle & (idle_cnt_q == CNT_W'(SUSPEND_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    bus_reset_d = 1'b0;
    resume_d    = 1'b0;
    if (!enable) begin
      state_d = StDisabled;
    end else begin
      unique case (state_q)
        StDisabled: state_d = StActive;
        StActive: begin
          if (se0_held) begin
            state_d     = StReset;
            bus_reset_d = 1'b1;
          end else if (idle_held) begin
            state_d = StSuspend;
          end
        end
        // Busy is deliberately ignored here: only a non-SE0 line ends reset.
        StReset: begin
          if (line_state != LsSe0) state_d = StActive;
        end
        StSuspend: begin
          if (line_state == LsDk) begin
            state_d  = StActive;
            resume_d = 1'b1;
          end else if (se0_held) begin
            state_d     = StReset;
            bus_reset_d = 1'b1;
          end
        end
        default: state_d = StDisabled;
      endcase
    end

    // Counters restart on every state change so each state times from zero.
    if (!enable || (state_d != state_q)) begin
      se0_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      if (!se0) begin
        se0_cnt_d = '0;
      end else if (se0_cnt_q == CNT_W'(RESET_CYCLES)) begin
        se0_cnt_d = se0_cnt_q;
      end else begin
        se0_cnt_d = se0_cnt_q + CNT_W'(1);
      end
      if (!idle) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == CNT_W'(SUSPEND_CYCLES)) begin
        idle_cnt_d = idle_cnt_q;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs are registered from the next state so they move with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDisabled;
      se0_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      op_mode     <= OmNonDrive;
      term_select <= 1'b0;
      bus_reset   <= 1'b0;
      in_reset    <= 1'b0;
      suspend     <= 1'b0;
      resume      <= 1'b0;
    end else begin
      state_q     <= state_d;
      se0_cnt_q   <= se0_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      op_mode     <= (state_d == StDisabled) ? OmNonDrive : OmNormal;
      term_select <= (state_d != StDisabled);
      bus_reset   <= bus_reset_d;
      in_reset    <= (state_d == StReset);
      suspend     <= (state_d == StSuspend);
      resume      <= resume_d;
    end
  end

  assign link_state = state_q;

endmodule

// File: tb/tb_usb_utmi_link_ctrl.sv
// Bench for usb_utmi_link_ctrl with short thresholds (reset 8, suspend 32).
module tb_usb_utmi_link_ctrl;

  localparam int R = 8;
  localparam int S = 32;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] DJ  = 2'b01;
  localparam logic [1:0] DK  = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst, enable, rx_active, tx_valid;
  logic [1:0] line_state;
  logic [1:0] op_mode, link_state;
  logic       term_select, bus_reset, in_reset, suspend, resume;

  int checks   = 0;
  int failures = 0;

  usb_utmi_link_ctrl #(
    .RESET_CYCLES  (R),
    .SUSPEND_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .line_state (line_state),
    .rx_active  (rx_active),
    .tx_valid   (tx_valid),
    .op_mode    (op_mode),
    .term_select(term_select),
    .bus_reset  (bus_reset),
    .in_reset   (in_reset),
    .suspend    (suspend),
    .resume     (resume),
    .link_state (link_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: state as 0..3 and run lengths of consecutive qualifying
  // cycles since the last state change.
  int m_state    = 0;
  int m_se0_run  = 0;
  int m_idle_run = 0;
  bit m_br       = 0;
  bit m_rs       = 0;
  bit m_valid    = 0;

  always @(posedge clk) begin : model
    bit busy, q_se0, q_idle, br, rs;
    int run_se0, run_idle, nxt;
    if (rst) begin
      m_state    <= 0;
      m_se0_run  <= 0;
      m_idle_run <= 0;
      m_br       <= 0;
      m_rs       <= 0;
      m_valid    <= 1;
    end else begin
      busy     = rx_active | tx_valid;
      q_se0    = (line_state == SE0) && !busy;
      q_idle   = (line_state == DJ) && !busy;
      run_se0  = q_se0 ? m_se0_run + 1 : 0;
      run_idle = q_idle ? m_idle_run + 1 : 0;
      nxt      = m_state;
      br       = 0;
      rs       = 0;
      if (!enable) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (m_state == 1) begin
        if (run_se0 >= R) begin nxt = 2; br = 1; end
        else if (run_idle >= S) nxt = 3;
      end else if (m_state == 2) begin
        if (line_state != SE0) nxt = 1;
      end else begin
        if (line_state == DK) begin nxt = 1; rs = 1; end
        else if (run_se0 >= R) begin nxt = 2; br = 1; end
      end
      if (!enable || nxt != m_state) begin
        run_se0  = 0;
        run_idle = 0;
      end
      m_state    <= nxt;
      m_se0_run  <= run_se0;
      m_idle_run <= run_idle;
      m_br       <= br;
      m_rs       <= rs;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("link_state", int'(link_state), m_state);
      check("op_mode", int'(op_mode), (m_state == 0) ? 1 : 0);
      check("term_select", int'(term_select), (m_state != 0) ? 1 : 0);
      check("in_reset", int'(in_reset), (m_state == 2) ? 1 : 0);
      check("suspend", int'(suspend), (m_state == 3) ? 1 : 0);
      check("bus_reset", int'(bus_reset), int'(m_br));
      check("resume", int'(resume), int'(m_rs));
    end
  end

  // Advance n edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    line_state = DJ;
    rx_active  = 1'b0;
    tx_valid   = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_link", int'(link_state), 0);
    check("rst_op_mode", int'(op_mode), 1);
    check("rst_term", int'(term_select), 0);
    check("rst_pulses", int'({bus_reset, resume, in_reset, suspend}), 0);

    // Connect, then 8 SE0 cycles -> RESET on the 8th edge.
    enable = 1'b1;
    tick(1);
    check("en_link", int'(link_state), 1);
    check("en_op_mode", int'(op_mode), 0);
    check("en_term", int'(term_select), 1);
    line_state = SE0;
    tick(7);
    check("se0_7_link", int'(link_state), 1);
    tick(1);
    check("se0_8_link", int'(link_state), 2);
    check("se0_8_bus_reset", int'(bus_reset), 1);
    check("se0_8_in_reset", int'(in_reset), 1);
    tick(1);
    check("reset_pulse_once", int'(bus_reset), 0);
    check("reset_hold", int'(in_reset), 1);
    line_state = DJ;
    tick(1);
    check("reset_exit_link", int'(link_state), 1);
    check("reset_exit_in_reset", int'(in_reset), 0);

    // Seven-cycle SE0 bursts never reach RESET.
    for (int i = 0; i < 3; i++) begin
      line_state = SE0;
      tick(7);
      line_state = DJ;
      tick(1);
    end
    check("se0_short_link", int'(link_state), 1);

    // Busy on cycle 4 restarts the SE0 count.
    line_state = SE0;
    tick(3);
    rx_active = 1'b1;
    tick(1);
    rx_active = 1'b0;
    tick(7);
    check("busy_restart_link", int'(link_state), 1);
    tick(1);
    check("busy_restart_reset", int'(link_state), 2);
    line_state = DJ;
    tick(1);
    check("busy_restart_exit", int'(link_state), 1);

    // 32 idle-J cycles -> SUSPEND; one K -> ACTIVE with a resume pulse.
    tick(S - 1);
    check("idle_31_link", int'(link_state), 1);
    tick(1);
    check("idle_32_link", int'(link_state), 3);
    check("idle_32_suspend", int'(suspend), 1);
    check("susp_op_mode", int'(op_mode), 0);
    line_state = DK;
    tick(1);
    check("resume_link", int'(link_state), 1);
    check("resume_pulse", int'(resume), 1);
    check("resume_suspend", int'(suspend), 0);
    line_state = DJ;
    tick(1);
    check("resume_once", int'(resume), 0);

    // Back to SUSPEND, SE1 holds it, then SE0 x8 -> RESET without resume.
    tick(S - 2);
    check("idle2_link", int'(link_state), 1);
    tick(1);
    check("idle2_suspend", int'(link_state), 3);
    line_state = SE1;
    tick(3);
    check("se1_stay", int'(link_state), 3);
    line_state = SE0;
    tick(R - 1);
    check("susp_se0_7", int'(link_state), 3);
    tick(1);
    check("susp_se0_8", int'(link_state), 2);
    check("susp_bus_reset", int'(bus_reset), 1);
    check("susp_no_resume", int'(resume), 0);

    // Disable mid-RESET, then re-enable with the idle count from zero.
    enable = 1'b0;
    tick(1);
    check("dis_link", int'(link_state), 0);
    check("dis_op_mode", int'(op_mode), 1);
    check("dis_term", int'(term_select), 0);
    check("dis_in_reset", int'(in_reset), 0);
    enable     = 1'b1;
    line_state = DJ;
    tick(1);
    check("reen_link", int'(link_state), 1);
    tick(S - 1);
    check("reen_idle_31", int'(link_state), 1);
    tick(1);
    check("reen_idle_32", int'(link_state), 3);

    // Disable mid-SUSPEND.
    enable = 1'b0;
    tick(1);
    check("dis_susp_link", int'(link_state), 0);
    check("dis_susp_suspend", int'(suspend), 0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
